cla_sequencer: RTL and testbench
================================

CLA_SEQUENCER -- requirements
Module: cla_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, meaning operand width in 4-bit slices; W = 4*NIBBLES; legal range 2..8.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit, with synchronous active-high reset.
REQ-004 The block SHALL have port START, input, 1 bit, meaning an operation request, sampled only in IDLE.
REQ-005 The block SHALL have port SUB, input, 1 bit, meaning 0 = add and 1 = subtract (OP_A - OP_B), sampled with START.
REQ-006 The block SHALL have port CIN, input, 1 bit, meaning carry-in for add, sampled with START and ignored when SUB=1.
REQ-007 The block SHALL have ports OP_A and OP_B, input, W bits each, meaning the operands, sampled with START.
REQ-008 The block SHALL have port RESULT, output, W bits, meaning the registered sum or difference.
REQ-009 The block SHALL have port COUT, output, 1 bit, meaning the final carry (for subtract, 1 = no borrow).
REQ-010 The block SHALL have port OVF, output, 1 bit, meaning signed overflow (see Configuration).
REQ-011 The block SHALL have port BUSY, output, 1 bit, high while in RUN.
REQ-012 The block SHALL have port DONE, output, 1 bit, a one-cycle completion pulse.

Function
REQ-013 The block SHALL instantiate exactly one carry_lookahead (ports A, B, CIN, SUM, COUT, 4-bit) and time-multiplex all slices through it.
REQ-014 The FSM SHALL have states IDLE, RUN and FIN; encoding is free.
REQ-015 In IDLE with START=1 at edge N, the block SHALL latch OP_A, OP_B (inverted if SUB) and SUB, set carry register = SUB ? 1 : CIN, set slice counter = 0, and go to RUN.
REQ-016 In RUN, each edge SHALL write adder SUM for slice cnt into RESULT[4*cnt+3:4*cnt], load carry register from adder COUT, and increment cnt.
REQ-017 The adder inputs SHALL be combinational selections of latched operand slice cnt and the carry register.
REQ-018 On the RUN edge where cnt = NIBBLES-1, the block SHALL go to FIN and update COUT from the final adder COUT.
REQ-019 DONE SHALL be high exactly during FIN, i.e. between edges N+NIBBLES and N+NIBBLES+1; FIN SHALL return to IDLE unconditionally.
REQ-020 START in RUN or FIN SHALL be ignored (no queuing); START may be accepted at the first edge back in IDLE.
REQ-021 RESULT, COUT and OVF SHALL hold their values from the last completed operation until the next FIN; partial slices of RESULT change during RUN.
REQ-022 Operand changes after the START edge SHALL NOT affect the operation in progress.
REQ-023 Arithmetic SHALL be modulo 2^W; COUT SHALL be bit W of OP_A + OP_B' + carry-in.

Reset
REQ-024 RST=1 at an edge SHALL force IDLE, cnt=0, carry register=0, RESULT=0, COUT=0, OVF=0, BUSY=0, DONE=0, overriding START.
REQ-025 RST asserted mid-RUN SHALL abandon the operation with no DONE pulse; the first START after reset releases SHALL behave normally.

Configuration
REQ-026 With macro CLA_SEQ_OVF_EN defined, OVF SHALL be set at the FIN transition to (A[W-1] == B'[W-1]) && (RESULT[W-1] != A[W-1]), using latched and possibly inverted B.
REQ-027 Without CLA_SEQ_OVF_EN, OVF SHALL be tied to 0 and no overflow logic SHALL be synthesized.

Verification (NIBBLES=4)
REQ-028 Add: START with A=16'h1234, B=16'h0FFF, CIN=0 -> BUSY for 4 cycles, DONE on 5th cycle after START edge, RESULT=16'h2233, COUT=0.
REQ-029 Ripple across slices: A=16'hFFFF, B=16'h0000, CIN=1 -> RESULT=16'h0000, COUT=1; with OVF_EN, OVF=0.
REQ-030 Subtract: A=16'h0005, B=16'h0007, SUB=1 -> RESULT=16'hFFFE, COUT=0; then A=16'h8000, B=16'h0001 -> RESULT=16'h7FFF, OVF=1 (if enabled).
REQ-031 Busy ignore: a second START pulse during RUN with different operands -> exactly one DONE, result of first operands only; back-to-back START at the IDLE edge after FIN is accepted.
REQ-032 Reset mid-op: RST pulse two cycles after START -> no DONE, all outputs 0, next add 16'h0001+16'h0001 gives 16'h0002.
REQ-033 Exhaustive slice check: loop all A,B nibble patterns replicated across 4 slices with CIN 0/1 -> RESULT/COUT match a reference model on every DONE.

Source files
------------

// File: rtl/cla_sequencer.sv
// cla_sequencer: W-bit add/subtract computed one 4-bit slice per clock
// through a single shared 4-bit carry-lookahead adder.
// Optional feature: define CLA_SEQ_OVF_EN to enable the signed-overflow flag
// on OVF; otherwise OVF is constant 0 and no overflow logic exists.

// 4-bit carry-lookahead adder slice.
module carry_lookahead (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       COUT
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and fully expanded lookahead carries.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c[0] = CIN;
    c[1] = g[0] | (p[0] & CIN);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & CIN);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & CIN);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & CIN);
  end

  assign SUM  = p ^ c[3:0];
  assign COUT = c[4];

endmodule

module cla_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SUB,
  input  logic                 CIN,
  input  logic [4*NIBBLES-1:0] OP_A,
  input  logic [4*NIBBLES-1:0] OP_B,
  output logic [4*NIBBLES-1:0] RESULT,
  output logic                 COUT,
  output logic                 OVF,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = $clog2(NIBBLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0]    a_slice_c;
  logic [3:0]    b_slice_c;
  logic [3:0]    sum_c;
  logic          co_c;

  // Current slice of the latched operands feeds the shared adder.
  assign a_slice_c = 4'(a_q >> {cnt_q, 2'b00});
  assign b_slice_c = 4'(b_q >> {cnt_q, 2'b00});

  carry_lookahead u_cla (
    .A    (a_slice_c),
    .B    (b_slice_c),
    .CIN  (carry_q),
    .SUM  (sum_c),
    .COUT (co_c)
  );

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  assign OVF = ovf_q;
`else
  assign OVF = 1'b0;
`endif

  // Next-state and datapath update; SUB is folded into b_q and carry_q.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = OP_A;
          b_d     = SUB ? ~OP_B : OP_B;
          carry_d = SUB ? 1'b1 : CIN;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[{cnt_q, 2'b00} +: 4] = sum_c;
        carry_d = co_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NIBBLES - 1)) begin
          cnt_d   = '0;
          cout_d  = co_c;
          state_d = FIN;
`ifdef CLA_SEQ_OVF_EN
          ovf_d = (a_q[W-1] == b_q[W-1]) && (sum_c[3] != a_q[W-1]);
`endif
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign RESULT = result_q;
  assign COUT   = cout_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_cla_sequencer.sv
// Scoreboard bench for cla_sequencer (NIBBLES=4): the driver pushes expected
// results, a monitor pops and compares on every DONE.
module tb_cla_sequencer;

`ifdef CLA_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        o;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        SUB = 1'b0;
  logic        CIN = 1'b0;
  logic [15:0] OP_A = '0;
  logic [15:0] OP_B = '0;
  logic [15:0] RESULT;
  logic        COUT;
  logic        OVF;
  logic        BUSY;
  logic        DONE;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  cla_sequencer #(.NIBBLES(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SUB    (SUB),
    .CIN    (CIN),
    .OP_A   (OP_A),
    .OP_B   (OP_B),
    .RESULT (RESULT),
    .COUT   (COUT),
    .OVF    (OVF),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic c, input logic o);
    exp_t e;
    e.r = r;
    e.c = c;
    e.o = OVF_ON & o;
    return e;
  endfunction

  // Reference arithmetic for the sweep.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] s;
    bb  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + 17'(sub ? 1'b1 : cin);
    e.r = s[15:0];
    e.c = s[16];
    e.o = OVF_ON & (a[15] == bb[15]) & (s[15] != a[15]);
    return e;
  endfunction

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge CLK) begin
    if (DONE) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h want no DONE", RESULT);
      end else begin
        e = sb.pop_front();
        check("result", 32'(RESULT), 32'(e.r));
        check("cout", 32'(COUT), 32'(e.c));
        check("ovf", 32'(OVF), 32'(e.o));
      end
    end
  end

  // Raise START for one edge; operands are scrambled right after.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic cin, input bit push, input exp_t e);
    @(posedge CLK);
    #1;
    START = 1'b1;
    OP_A  = a;
    OP_B  = b;
    SUB   = sub;
    CIN   = cin;
    if (push) sb.push_back(e);
    @(posedge CLK);
    #1;
    START = 1'b0;
    OP_A  = ~a;
    OP_B  = ~b;
    SUB   = ~sub;
    CIN   = ~cin;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 40) begin
      @(negedge CLK);
      #1;
      k++;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL done_timeout: got done_cnt %0d want %0d", done_cnt, target);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_result", 32'(RESULT), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    check("rst_cout", 32'(COUT), 32'h0);

    // Add with BUSY/DONE timing.
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, mk(16'h2233, 1'b0, 1'b0));
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge CLK);
      check($sformatf("busy_c%0d", cyc), 32'(BUSY), 32'(cyc <= 4));
      check($sformatf("done_c%0d", cyc), 32'(DONE), 32'(cyc == 5));
    end
    #1;
    wait_done(1);

    // Ripple across all slices.
    issue(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, mk(16'h0000, 1'b1, 1'b0));
    wait_done(done_cnt + 1);

    // Subtract, then subtract with signed overflow.
    issue(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    wait_done(done_cnt + 1);
    issue(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
    wait_done(done_cnt + 1);

    // START during RUN is ignored.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, mk(16'h3333, 1'b0, 1'b0));
    @(posedge CLK);
    #1;
    START = 1'b1;
    OP_A  = 16'hFFFF;
    OP_B  = 16'hFFFF;
    SUB   = 1'b0;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done(done_cnt + 1);

    // Back-to-back: START held from DONE is taken at the first IDLE edge.
    START = 1'b1;
    OP_A  = 16'h0001;
    OP_B  = 16'h0003;
    SUB   = 1'b0;
    CIN   = 1'b1;
    sb.push_back(mk(16'h0005, 1'b0, 1'b0));
    @(posedge CLK);
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    check("b2b_busy", 32'(BUSY), 32'h1);
    #1;
    wait_done(done_cnt + 1);

    // Reset two cycles into an operation: no DONE, outputs cleared.
    issue(16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0));
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_result", 32'(RESULT), 32'h0);
    check("mid_rst_cout", 32'(COUT), 32'h0);
    check("mid_rst_ovf", 32'(OVF), 32'h0);
    check("mid_rst_busy", 32'(BUSY), 32'h0);
    check("mid_rst_done", 32'(DONE), 32'h0);
    repeat (8) @(posedge CLK);
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0002, 1'b0, 1'b0));
    wait_done(done_cnt + 1);

    // Every nibble pair replicated over all slices, both carry-ins.
    for (int na = 0; na < 16; na++) begin
      for (int nb = 0; nb < 16; nb++) begin
        for (int c = 0; c < 2; c++) begin
          logic [15:0] a;
          logic [15:0] b;
          a = {4{4'(na)}};
          b = {4{4'(nb)}};
          issue(a, b, 1'b0, 1'(c), 1'b1, model(a, b, 1'b0, 1'(c)));
          wait_done(done_cnt + 1);
        end
      end
    end

    repeat (4) @(posedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
